// File: rtl/ram_burst_responder_pkg.sv
// Shared constants and types for the RAM-side burst responder.
// Holds the line/bus geometry shared with the cache/MI side, the default
// latencies, and the responder FSM state encoding.
package ram_burst_responder_pkg;

  localparam int c_ADDR_SIZE         = 16;
  localparam int c_RAM_BUS_SIZE      = 16;
  localparam int c_RAM_DATA_SIZE     = 128;
  localparam int c_RAM_BEATS         = c_RAM_DATA_SIZE / c_RAM_BUS_SIZE;
  localparam int c_RAM_DEPTH_LINES   = 64;
  localparam int c_RAM_READ_LATENCY  = 4;
  localparam int c_RAM_WRITE_LATENCY = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_XFER = 3'd2,
    ST_DONE = 3'd3,
    ST_HOLD = 3'd4
  } ram_state_e;

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ram_burst_responder_storage.sv
// Line storage for the burst responder: DEPTH_LINES lines of BEATS beats.
// Ports:
//   clk                      write clock
//   rd_index/rd_beat         combinational beat read -> rd_data
//   we/wr_index/wr_beat      synchronous beat write of wr_data
// No reset: contents persist across responder reset.
module ram_line_storage
  import ram_burst_responder_pkg::*;
#(
  parameter int BUS_SIZE    = c_RAM_BUS_SIZE,
  parameter int BEATS       = c_RAM_BEATS,
  parameter int DEPTH_LINES = c_RAM_DEPTH_LINES,
  parameter int IDX_W       = $clog2(DEPTH_LINES),
  parameter int CNT_W       = clog2_min1(BEATS)
) (
  input  logic                clk,
  input  logic [IDX_W-1:0]    rd_index,
  input  logic [CNT_W-1:0]    rd_beat,
  output logic [BUS_SIZE-1:0] rd_data,
  input  logic                we,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [CNT_W-1:0]    wr_beat,
  input  logic [BUS_SIZE-1:0] wr_data
);

  logic [BEATS-1:0][BUS_SIZE-1:0] mem [DEPTH_LINES];

  assign rd_data = mem[rd_index][rd_beat];

  always_ff @(posedge clk) begin
    if (we) mem[wr_index][wr_beat] <= wr_data;
  end

endmodule

// File: rtl/ram_burst_responder.sv
// RAM-side responder for MemoryInterface: serves whole-line transfers as
// BEATS bus-width beats with fixed read/write latency.
// Ports:
//   RAM_CLK, RAM_RESET_N     clock, async active-low reset
//   RAM_REQ                  level request, held for the whole transfer
//   RAM_READ_NOT_WRITE       1 = line read, 0 = line write
//   OUT_RAM_ADDR             byte address (offset ignored, index wraps)
//   OUT_RAM_DATA             write beat from MI
//   IN_RAM_DATA              read beat, zero unless RAM_ACK
//   RAM_ACK                  one strobe per beat
//   RAM_DONE                 one-cycle pulse after the last beat
//   RAM_BUSY                 high whenever not idle
module ram_burst_responder
  import ram_burst_responder_pkg::*;
#(
  parameter int ADDR_SIZE     = c_ADDR_SIZE,
  parameter int BUS_SIZE      = c_RAM_BUS_SIZE,
  parameter int LINE_SIZE     = c_RAM_DATA_SIZE,
  parameter int DEPTH_LINES   = c_RAM_DEPTH_LINES,
  parameter int READ_LATENCY  = c_RAM_READ_LATENCY,
  parameter int WRITE_LATENCY = c_RAM_WRITE_LATENCY
) (
  input  logic                 RAM_CLK,
  input  logic                 RAM_RESET_N,
  input  logic                 RAM_REQ,
  input  logic                 RAM_READ_NOT_WRITE,
  input  logic [ADDR_SIZE-1:0] OUT_RAM_ADDR,
  input  logic [BUS_SIZE-1:0]  OUT_RAM_DATA,
  output logic [BUS_SIZE-1:0]  IN_RAM_DATA,
  output logic                 RAM_ACK,
  output logic                 RAM_DONE,
  output logic                 RAM_BUSY
);

  localparam int BEATS = LINE_SIZE / BUS_SIZE;
  localparam int OFS_W = $clog2(LINE_SIZE / 8);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = clog2_min1(BEATS);
  localparam int LAT_W = clog2_min1((READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY);

  ram_state_e          state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q;
  logic                rnw_q;
  logic                accept, we;
  logic [BUS_SIZE-1:0] rd_beat;
  logic                ack_q, done_q, busy_q;
  logic [BUS_SIZE-1:0] data_q;

  // Byte offset and wrap-around upper bits are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{OUT_RAM_ADDR[OFS_W-1:0], OUT_RAM_ADDR[ADDR_SIZE-1:OFS_W+IDX_W]};

  assign accept = (state_q == ST_IDLE) && RAM_REQ;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    unique case (state_q)
      ST_IDLE: if (RAM_REQ) begin
        state_d = ST_WAIT;
        lat_d   = RAM_READ_NOT_WRITE ? LAT_W'(READ_LATENCY - 1) : LAT_W'(WRITE_LATENCY - 1);
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (!RAM_REQ)          state_d = ST_IDLE;
        else if (lat_q == '0)  state_d = ST_XFER;
        else                   lat_d   = lat_q - 1'b1;
      end
      ST_XFER: begin
        // A dropped request aborts before this cycle's beat commits.
        if (!RAM_REQ) state_d = ST_IDLE;
        else begin
          we = !rnw_q;
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = ST_DONE;
          else                            cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: if (!RAM_REQ) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read port is addressed with the next beat so the data register loads
  // the beat that will be presented alongside the registered ACK.
  ram_line_storage #(
    .BUS_SIZE    (BUS_SIZE),
    .BEATS       (BEATS),
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W),
    .CNT_W       (CNT_W)
  ) u_storage (
    .clk      (RAM_CLK),
    .rd_index (idx_q),
    .rd_beat  (cnt_d),
    .rd_data  (rd_beat),
    .we       (we),
    .wr_index (idx_q),
    .wr_beat  (cnt_q),
    .wr_data  (OUT_RAM_DATA)
  );

  always_ff @(posedge RAM_CLK or negedge RAM_RESET_N) begin
    if (!RAM_RESET_N) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rnw_q   <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q <= OUT_RAM_ADDR[OFS_W +: IDX_W];
        rnw_q <= RAM_READ_NOT_WRITE;
      end
      ack_q  <= (state_d == ST_XFER);
      done_q <= (state_d == ST_DONE);
      busy_q <= (state_d != ST_IDLE);
      data_q <= ((state_d == ST_XFER) && rnw_q) ? rd_beat : '0;
    end
  end

  assign IN_RAM_DATA = data_q;
  assign RAM_ACK     = ack_q;
  assign RAM_DONE    = done_q;
  assign RAM_BUSY    = busy_q;

endmodule

// File: tb/tb_ram_burst_responder.sv
module tb_ram_burst_responder;

  logic        RAM_CLK = 1'b0;
  logic        RAM_RESET_N;
  logic        RAM_REQ;
  logic        RAM_READ_NOT_WRITE;
  logic [15:0] OUT_RAM_ADDR;
  logic [15:0] OUT_RAM_DATA;
  logic [15:0] IN_RAM_DATA;
  logic        RAM_ACK, RAM_DONE, RAM_BUSY;

  int checks = 0;
  int errors = 0;

  // Reference model: whole lines, index = (addr / 16) mod 64.
  logic [127:0] ref_mem [64];
  bit           ref_known [64];

  // Observations from the last transfer.
  logic [127:0] obs_line;
  int  obs_nacks, obs_lat, obs_done, obs_done_edge;
  bit  obs_timeout, obs_hold_bad, obs_idle_after, obs_leak;

  ram_burst_responder dut (
    .RAM_CLK            (RAM_CLK),
    .RAM_RESET_N        (RAM_RESET_N),
    .RAM_REQ            (RAM_REQ),
    .RAM_READ_NOT_WRITE (RAM_READ_NOT_WRITE),
    .OUT_RAM_ADDR       (OUT_RAM_ADDR),
    .OUT_RAM_DATA       (OUT_RAM_DATA),
    .IN_RAM_DATA        (IN_RAM_DATA),
    .RAM_ACK            (RAM_ACK),
    .RAM_DONE           (RAM_DONE),
    .RAM_BUSY           (RAM_BUSY)
  );

  always #5 RAM_CLK = ~RAM_CLK;

  function automatic int line_of(input logic [15:0] a);
    return (int'(a) / 16) % 64;
  endfunction

  task automatic model_write(input logic [15:0] addr, input logic [127:0] line, input int nbeats);
    int i;
    logic [127:0] cur;
    i = line_of(addr);
    cur = ref_mem[i];
    for (int k = 0; k < nbeats; k++) cur[k*16 +: 16] = line[k*16 +: 16];
    ref_mem[i] = cur;
    if (nbeats == 8) ref_known[i] = 1'b1;
  endtask

  // Drives one transfer as the MI would and records what the responder did.
  task automatic xfer(input bit rnw, input logic [15:0] addr, input logic [127:0] line,
                      input int abort_after, input int hold_cycles, input bit chg_addr);
    int edges, post;
    bit aborted;
    obs_line = '0; obs_nacks = 0; obs_lat = -1; obs_done = 0; obs_done_edge = -1;
    obs_timeout = 0; obs_hold_bad = 0; obs_idle_after = 0; obs_leak = 0;
    @(negedge RAM_CLK);
    RAM_REQ = 1'b1; RAM_READ_NOT_WRITE = rnw; OUT_RAM_ADDR = addr; OUT_RAM_DATA = line[15:0];
    @(posedge RAM_CLK);
    edges = 0; post = 0; aborted = 0;
    forever begin
      @(negedge RAM_CLK);
      if (!RAM_ACK && IN_RAM_DATA !== 16'h0) obs_leak = 1;
      if (RAM_ACK && !aborted) begin
        if (obs_nacks < 8) obs_line[obs_nacks*16 +: 16] = IN_RAM_DATA;
        if (obs_lat < 0) obs_lat = edges;
        obs_nacks++;
        if (chg_addr) OUT_RAM_ADDR = addr ^ 16'h0230;
      end
      if (RAM_DONE) begin obs_done++; obs_done_edge = edges; end
      if (aborted) begin
        post++;
        if (post == 2) obs_idle_after = !RAM_BUSY && !RAM_ACK;
        if (post == 4) break;
      end else if (obs_done > 0) break;
      if (edges > 60) begin obs_timeout = 1; break; end
      @(posedge RAM_CLK);
      edges++;
      #1;
      if (abort_after > 0 && obs_nacks == abort_after && !aborted) begin
        RAM_REQ = 1'b0; aborted = 1;
      end
      if (!rnw && obs_nacks > 0 && obs_nacks < 8) OUT_RAM_DATA = line[obs_nacks*16 +: 16];
    end
    if (!aborted) begin
      for (int h = 0; h < hold_cycles; h++) begin
        @(negedge RAM_CLK);
        if (RAM_ACK || RAM_DONE || !RAM_BUSY) obs_hold_bad = 1;
      end
      RAM_REQ = 1'b0;
      repeat (2) @(negedge RAM_CLK);
      obs_idle_after = !RAM_BUSY;
    end
    RAM_REQ = 1'b0;
  endtask

  task automatic test_reset;
    RAM_RESET_N = 1'b0; RAM_REQ = 1'b1; RAM_READ_NOT_WRITE = 1'b1;
    OUT_RAM_ADDR = 16'h0120; OUT_RAM_DATA = 16'h0;
    repeat (5) @(negedge RAM_CLK);
    checks++; if (RAM_ACK !== 1'b0)  begin errors++; $display("FAIL reset_ack: got %b expected 0", RAM_ACK); end
    checks++; if (RAM_DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", RAM_DONE); end
    checks++; if (RAM_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", RAM_BUSY); end
    checks++; if (IN_RAM_DATA !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", IN_RAM_DATA); end
    RAM_RESET_N = 1'b1;
    @(negedge RAM_CLK);
    checks++; if (RAM_BUSY !== 1'b1) begin errors++; $display("FAIL reset_release_accept: busy %b expected 1", RAM_BUSY); end
    RAM_REQ = 1'b0;
    repeat (3) @(negedge RAM_CLK);
    checks++; if (RAM_BUSY !== 1'b0) begin errors++; $display("FAIL wait_abort_idle: busy %b expected 0", RAM_BUSY); end
  endtask

  task automatic test_write_read;
    logic [127:0] l;
    l = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    xfer(1'b0, 16'h0120, l, 0, 0, 0);
    model_write(16'h0120, l, 8);
    checks++; if (obs_nacks !== 8) begin errors++; $display("FAIL write_acks: got %0d expected 8", obs_nacks); end
    checks++; if (obs_done !== 1) begin errors++; $display("FAIL write_done: got %0d expected 1", obs_done); end
    checks++; if (obs_lat !== 2) begin errors++; $display("FAIL write_latency: got %0d expected 2", obs_lat); end
    checks++; if (obs_done_edge !== obs_lat + 8) begin errors++; $display("FAIL write_done_timing: got %0d expected %0d", obs_done_edge, obs_lat + 8); end
    checks++; if (!obs_idle_after) begin errors++; $display("FAIL write_idle_after: busy still set"); end
    xfer(1'b1, 16'h0120, '0, 0, 0, 0);
    checks++; if (obs_lat !== 4) begin errors++; $display("FAIL read_latency: got %0d expected 4", obs_lat); end
    checks++; if (obs_line !== l) begin errors++; $display("FAIL read_line: got %h expected %h", obs_line, l); end
    checks++; if (obs_done !== 1 || obs_done_edge !== 12) begin errors++; $display("FAIL read_done: count %0d at %0d expected 1 at 12", obs_done, obs_done_edge); end
    checks++; if (obs_leak) begin errors++; $display("FAIL read_data_leak: data nonzero without ACK"); end
  endtask

  task automatic test_offset_wrap;
    xfer(1'b1, 16'h012C, '0, 0, 0, 0);
    checks++; if (obs_line !== ref_mem[line_of(16'h012C)]) begin errors++; $display("FAIL offset_read: got %h expected %h", obs_line, ref_mem[line_of(16'h012C)]); end
    xfer(1'b1, 16'h0520, '0, 0, 0, 0);
    checks++; if (obs_line !== ref_mem[line_of(16'h0520)]) begin errors++; $display("FAIL wrap_read: got %h expected %h", obs_line, ref_mem[line_of(16'h0520)]); end
  endtask

  task automatic test_abort;
    logic [127:0] ffs;
    ffs = {8{16'hFFFF}};
    xfer(1'b0, 16'h0120, ffs, 3, 0, 0);
    model_write(16'h0120, ffs, 3);
    checks++; if (obs_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", obs_done); end
    checks++; if (obs_nacks !== 3) begin errors++; $display("FAIL abort_acks: got %0d expected 3", obs_nacks); end
    checks++; if (!obs_idle_after) begin errors++; $display("FAIL abort_idle: not idle after drop"); end
    xfer(1'b1, 16'h0120, '0, 0, 0, 0);
    checks++; if (obs_line !== 128'h0F0E_0D0C_0B0A_0908_0706_FFFF_FFFF_FFFF) begin errors++; $display("FAIL abort_readback: got %h expected 0f0e0d0c0b0a09080706ffffffffffff", obs_line); end
    checks++; if (obs_line !== ref_mem[18]) begin errors++; $display("FAIL abort_model: got %h expected %h", obs_line, ref_mem[18]); end
  endtask

  task automatic test_hold_and_addr_change;
    xfer(1'b1, 16'h0120, '0, 0, 5, 1);
    checks++; if (obs_hold_bad) begin errors++; $display("FAIL hold_no_retrigger: ack/done or idle seen while REQ held"); end
    checks++; if (!obs_idle_after) begin errors++; $display("FAIL hold_release: not idle after REQ low"); end
    checks++; if (obs_line !== ref_mem[18]) begin errors++; $display("FAIL latched_addr: got %h expected %h", obs_line, ref_mem[18]); end
  endtask

  task automatic test_reset_mid_burst;
    int acks;
    bit hit;
    logic [127:0] exp;
    acks = 0; hit = 0; exp = ref_mem[18];
    @(negedge RAM_CLK);
    RAM_REQ = 1'b1; RAM_READ_NOT_WRITE = 1'b1; OUT_RAM_ADDR = 16'h0120;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge RAM_CLK);
      if (RAM_ACK) begin
        acks++;
        if (acks == 5) begin
          hit = 1;
          checks++; if (IN_RAM_DATA !== exp[4*16 +: 16]) begin errors++; $display("FAIL beat4_data: got %h expected %h", IN_RAM_DATA, exp[4*16 +: 16]); end
          RAM_RESET_N = 1'b0;
          #1;
          checks++; if (RAM_ACK !== 1'b0 || IN_RAM_DATA !== 16'h0 || RAM_BUSY !== 1'b0) begin
            errors++; $display("FAIL reset_mid_burst: ack %b data %h busy %b expected 0 0000 0", RAM_ACK, IN_RAM_DATA, RAM_BUSY);
          end
        end
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL reset_mid_timeout: got %0d acks expected 5", acks); end
    RAM_REQ = 1'b0;
    @(negedge RAM_CLK);
    RAM_RESET_N = 1'b1;
    @(negedge RAM_CLK);
    xfer(1'b1, 16'h0120, '0, 0, 0, 0);
    checks++; if (obs_line !== exp || obs_nacks !== 8) begin errors++; $display("FAIL storage_survives_reset: got %h (%0d acks) expected %h", obs_line, obs_nacks, exp); end
  endtask

  task automatic test_random;
    logic [15:0]  a;
    logic [127:0] l;
    int ab;
    for (int it = 0; it < 20; it++) begin
      a = 16'($urandom);
      if (!ref_known[line_of(a)] || $urandom_range(0, 1) == 0) begin
        l = {$urandom, $urandom, $urandom, $urandom};
        ab = (ref_known[line_of(a)] && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
        xfer(1'b0, a, l, ab, 0, 0);
        model_write(a, l, (ab > 0) ? ab : 8);
        checks++; if (obs_nacks !== ((ab > 0) ? ab : 8) || obs_done !== ((ab > 0) ? 0 : 1) || obs_timeout) begin
          errors++; $display("FAIL rand_write: acks %0d done %0d abort %0d", obs_nacks, obs_done, ab);
        end
        checks++; if (obs_lat !== 2) begin errors++; $display("FAIL rand_write_lat: got %0d expected 2", obs_lat); end
      end else begin
        xfer(1'b1, a, '0, 0, 0, 0);
        checks++; if (obs_line !== ref_mem[line_of(a)] || obs_done !== 1 || obs_timeout) begin
          errors++; $display("FAIL rand_read @%h: got %h expected %h done %0d", a, obs_line, ref_mem[line_of(a)], obs_done);
        end
        checks++; if (obs_lat !== 4) begin errors++; $display("FAIL rand_read_lat: got %0d expected 4", obs_lat); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin ref_mem[i] = '0; ref_known[i] = 1'b0; end
    test_reset;
    test_write_read;
    test_offset_wrap;
    test_abort;
    test_hold_and_addr_change;
    test_reset_mid_burst;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
